ysyx_24090018_ifu: RTL and testbench
====================================

# ysyx_24090018_ifu

Instruction fetch unit sitting between the PC register and the decode stage. Each fetch takes the current PC, issues one read on the instruction-memory bus, captures the returned word, and holds it for decode with a valid/ready handshake. When decode accepts the word, the block pulses `pc_update_o` so the PC register advances to PC+4 or to the jump target. Bus errors, misaligned PCs and unresponsive memory are reported as fault codes alongside the instruction.

## Interface
- `ADDR_WIDTH`, 32, fetch address width.
- `DATA_WIDTH`, 32, instruction width.
- `TIMEOUT`, 255, maximum cycles spent in `R` waiting for `rvalid_i`; the counter is 8 bits wide.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `pc_i`  in  ADDR_WIDTH  current PC from the PC register.
- `pc_update_o`  out  1  one-cycle strobe; the PC register loads its next value on this edge.
- `araddr_o`  out  ADDR_WIDTH  read address; equals `pc_i`.
- `arvalid_o`  out  1  read address valid.
- `arready_i`  in  1  memory accepts the address.
- `rvalid_i`  in  1  read data valid.
- `rready_o`  out  1  IFU accepts the read data.
- `rdata_i`  in  DATA_WIDTH  read data.
- `rresp_i`  in  2  read response; nonzero means error.
- `inst_valid_o`  out  1  instruction held for decode.
- `inst_ready_i`  in  1  decode accepts the instruction.
- `inst_o`  out  DATA_WIDTH  fetched instruction.
- `inst_pc_o`  out  ADDR_WIDTH  PC of `inst_o`.
- `inst_fault_o`  out  2  0 = ok, 1 = misaligned, 2 = bus error, 3 = timeout.

## Operation
- FSM states: `IDLE`, `AR`, `R`, `HOLD`.
- `IDLE`
  - Entered from reset.
  - Moves to `AR` unconditionally on the next cycle.
- `AR`
  - If `pc_i[1:0] != 0`: no bus request; `arvalid_o` stays 0. Go to `HOLD` with `inst_o` = NOP (32'h00000013), `inst_fault_o` = 1, `inst_pc_o` = `pc_i`.
  - Otherwise `arvalid_o` = 1.
  - On `arvalid_o && arready_i`: latch `inst_pc_o <= pc_i`, clear the timeout counter, go to `R`.
- `R`
  - `rready_o` = 1.
  - On `rvalid_i` with `rresp_i == 0`: `inst_o <= rdata_i`, fault 0, go to `HOLD`.
  - On `rvalid_i` with `rresp_i != 0`: `inst_o` = NOP, fault 2, go to `HOLD`.
  - Each cycle without `rvalid_i`, the counter increments. When the counter equals `TIMEOUT` and `rvalid_i` is still 0: NOP, fault 3, go to `HOLD`.
- `HOLD`
  - `inst_valid_o` = 1; `inst_o`, `inst_pc_o` and `inst_fault_o` are stable.
  - On `inst_ready_i`: `pc_update_o` = 1 (combinational, `inst_valid_o && inst_ready_i`), go to `AR`.
- `pc_i` changes only on a `pc_update_o` edge, so `araddr_o` is stable for the whole `AR` state.
- `rvalid_i` outside `R` is ignored. The memory must not respond to a request that has timed out.
- Fault handling (trap or halt) belongs to downstream logic; the IFU only reports the code.

## Timing
- Reset values (applied while `rst` = 0 at a clock edge):
  - State = `IDLE`.
  - `arvalid_o`, `rready_o`, `inst_valid_o`, `pc_update_o` = 0.
  - `inst_o` = 32'h00000013, `inst_pc_o` = 0, `inst_fault_o` = 0, counter = 0.
- Reset mid-fetch (any state): the next cycle is `IDLE` with all handshake outputs low. An in-flight bus response is dropped.
- Best case, with `arready_i` = 1 and `rvalid_i` arriving the cycle after the address:
  - cycle N: `AR`
  - cycle N+1: `R`
  - cycle N+2: `HOLD`, `inst_valid_o` = 1
- Minimum fetch period is 3 cycles per instruction, with back-to-back acceptance by decode.
- Misaligned PC: `AR` to `HOLD` in 1 cycle; no `arvalid_o` pulse at any point.
- Timeout: `HOLD` is reached `TIMEOUT`+1 cycles after entering `R`.
- Handshakes:
  - `arvalid_o` and `inst_valid_o` never drop without the matching ready.
  - The payload is stable while valid is high.
- `rvalid_i` arriving in the same cycle the counter hits `TIMEOUT` is treated as data; data takes priority over timeout.
- `pc_update_o` is asserted only in `HOLD`, for exactly one cycle per accepted instruction.

## Structure
- `defines.v` holds:
  - FSM state encodings.
  - Fault codes `IFU_FAULT_*`.
  - The NOP encoding.
  - The reset-enable level for active-low `rst`.
  - The reset value of `inst_pc_o`.
- No sub-module. One file containing:
  - the state register,
  - the timeout counter,
  - the output holding registers,
  - combinational next-state and handshake logic.

## Test plan
- Aligned fetch, zero-wait memory: `pc_i` = 0x80000000, `rdata_i` = 0x00100093 one cycle after `arready_i`. Required: `inst_valid_o` 2 cycles after `AR`, `inst_o` = 0x00100093, `inst_pc_o` = 0x80000000, fault 0. `pc_update_o` pulses on the `inst_ready_i` cycle.
- Backpressure: `arready_i` low for 3 cycles, then `inst_ready_i` low for 4 cycles. Required: `arvalid_o`/`araddr_o` and `inst_valid_o`/`inst_o` held stable throughout; exactly one `pc_update_o`.
- Misaligned: `pc_i` = 0x80000002. Required: no `arvalid_o`, `HOLD` next cycle, `inst_o` = 0x00000013, fault 1.
- Bus error: `rresp_i` = 2 with `rvalid_i`. Required: fault 2, NOP. Timeout: `rvalid_i` never asserted with `TIMEOUT` = 4. Required: `HOLD` with fault 3 after 5 `R` cycles.
- Reset mid-`R`: `rst` = 0 for one cycle, then `rvalid_i` = 1. Required: `IDLE` with all outputs at reset values, response ignored, new `AR` on the following cycle.

Source files
------------

// File: rtl/ysyx_24090018_ifu_pkg.sv
// Shared encodings for the instruction fetch unit: FSM states, fault codes,
// the NOP used for faulted fetches, reset level and reset PC.
package ysyx_24090018_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_AR   = 2'd1,
        IFU_R    = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    typedef enum logic [1:0] {
        IFU_FAULT_OK       = 2'd0,
        IFU_FAULT_MISALIGN = 2'd1,
        IFU_FAULT_BUS      = 2'd2,
        IFU_FAULT_TIMEOUT  = 2'd3
    } ifu_fault_e;

    // addi x0, x0, 0
    localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

    // rst is active-low: this is the level that resets the block
    localparam logic        IFU_RST_EN   = 1'b0;

    localparam logic [31:0] IFU_PC_RESET = 32'h0000_0000;

    // Instructions are word aligned; any set low bit is a misaligned fetch
    function automatic logic ifu_pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_24090018_ifu.sv
// Instruction fetch unit: issues one read per PC, captures the returned word
// (or a NOP plus fault code) and presents it to decode with valid/ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | just out of reset, moves to AR next cycle
// AR    | address phase; misaligned PCs skip the bus and fault directly
// R     | waiting for read data, timeout counter running
// HOLD  | instruction presented to decode; acceptance pulses pc_update_o
module ysyx_24090018_ifu
    import ysyx_24090018_ifu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc_i,
    output logic                  pc_update_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    output logic                  inst_valid_o,
    input  logic                  inst_ready_i,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] inst_pc_o,
    output logic [1:0]            inst_fault_o
);

    localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [DATA_WIDTH-1:0] NOP_INST    = DATA_WIDTH'(IFU_NOP);
    localparam logic [ADDR_WIDTH-1:0] PC_RESET    = ADDR_WIDTH'(IFU_PC_RESET);

    ifu_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic [1:0]            fault_q, fault_d;

    // Address is always the live PC; it only moves on a pc_update_o edge
    assign araddr_o     = pc_i;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_fault_o = fault_q;

    // Next-state, payload capture and handshake outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        arvalid_o    = 1'b0;
        rready_o     = 1'b0;
        inst_valid_o = 1'b0;
        pc_update_o  = 1'b0;

        case (state_q)
            IFU_IDLE: begin
                state_d = IFU_AR;
            end

            IFU_AR: begin
                if (ifu_pc_misaligned(pc_i[1:0])) begin
                    inst_d    = NOP_INST;
                    fault_d   = IFU_FAULT_MISALIGN;
                    inst_pc_d = pc_i;
                    state_d   = IFU_HOLD;
                end else begin
                    arvalid_o = 1'b1;
                    if (arready_i) begin
                        inst_pc_d = pc_i;
                        cnt_d     = 8'd0;
                        state_d   = IFU_R;
                    end
                end
            end

            IFU_R: begin
                rready_o = 1'b1;
                // Data arriving on the terminal count still wins over timeout
                if (rvalid_i) begin
                    if (rresp_i == 2'b00) begin
                        inst_d  = rdata_i;
                        fault_d = IFU_FAULT_OK;
                    end else begin
                        inst_d  = NOP_INST;
                        fault_d = IFU_FAULT_BUS;
                    end
                    state_d = IFU_HOLD;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    inst_d  = NOP_INST;
                    fault_d = IFU_FAULT_TIMEOUT;
                    state_d = IFU_HOLD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            IFU_HOLD: begin
                inst_valid_o = 1'b1;
                if (inst_ready_i) begin
                    pc_update_o = 1'b1;
                    state_d     = IFU_AR;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    // State, counter and payload registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (rst == IFU_RST_EN) begin
            state_q   <= IFU_IDLE;
            cnt_q     <= 8'd0;
            inst_q    <= NOP_INST;
            inst_pc_q <= PC_RESET;
            fault_q   <= IFU_FAULT_OK;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            fault_q   <= fault_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24090018_ifu.sv
// Testbench for the fetch unit: a memory/decode driver issues directed and
// random fetches, pushing the model's expected result into a scoreboard that
// an independent monitor checks on every cycle the instruction is presented.
module tb_ysyx_24090018_ifu;

    localparam int TMO = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_update_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic [1:0]  inst_fault_o;

    ysyx_24090018_ifu #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT   (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_i        (pc_i),
        .pc_update_o (pc_update_o),
        .araddr_o    (araddr_o),
        .arvalid_o   (arvalid_o),
        .arready_i   (arready_i),
        .rvalid_i    (rvalid_i),
        .rready_o    (rready_o),
        .rdata_i     (rdata_i),
        .rresp_i     (rresp_i),
        .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i),
        .inst_o      (inst_o),
        .inst_pc_o   (inst_pc_o),
        .inst_fault_o(inst_fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        int          ar_dly;    // AR cycles with arvalid before arready
        int          r_dly;     // R cycles before rvalid (beyond TMO = never)
        logic [1:0]  resp;
        logic [31:0] data;
        int          hold_dly;  // HOLD cycles before inst_ready
    } txn_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference result of one fetch, straight from the fetch rules
    function automatic exp_t model(input txn_t t);
        exp_t e;
        e.pc = t.pc;
        if (t.pc[1:0] != 2'b00) begin
            e.inst = NOP; e.fault = 2'd1;
        end else if (t.r_dly > TMO) begin
            e.inst = NOP; e.fault = 2'd3;
        end else if (t.resp != 2'b00) begin
            e.inst = NOP; e.fault = 2'd2;
        end else begin
            e.inst = t.data; e.fault = 2'd0;
        end
        return e;
    endfunction

    // Cycles from entering AR to first HOLD cycle
    function automatic int model_latency(input txn_t t);
        if (t.pc[1:0] != 2'b00) return 1;
        return (t.ar_dly + 1) + (((t.r_dly > TMO) ? TMO : t.r_dly) + 1);
    endfunction

    // Called with the DUT about to enter AR on the next clock edge.
    task automatic run_txn(input txn_t t);
        int cyc = 0, arw = 0, rc = 0, hc = 0;
        bit saw_ar = 0, done = 0;
        pc_i = t.pc;
        sb_q.push_back(model(t));
        while (!done) begin
            @(negedge clk);
            if (cyc > 1000) begin
                $display("FAIL watchdog: fetch of pc %0h stuck for %0d cycles", t.pc, cyc);
                $display("%0d/%0d checks passed", n_pass, n_total + 1);
                $fatal(1, "fetch timeout");
            end
            if (arvalid_o) begin
                saw_ar = 1;
                chk("araddr", araddr_o, t.pc);
                arready_i = (arw >= t.ar_dly);
                arw++;
            end else begin
                arready_i = 1'($urandom_range(0, 1));
            end
            if (rready_o) begin
                rvalid_i = (rc == t.r_dly);
                rresp_i  = t.resp;
                rdata_i  = t.data;
                rc++;
            end else begin
                rvalid_i = 1'($urandom_range(0, 1));
                rresp_i  = 2'($urandom_range(0, 3));
                rdata_i  = $urandom;
            end
            if (inst_valid_o) begin
                if (hc == 0) chk("latency", 64'(cyc), 64'(model_latency(t)));
                inst_ready_i = (hc >= t.hold_dly);
                if (inst_ready_i) done = 1;
                hc++;
            end else begin
                inst_ready_i = 1'($urandom_range(0, 1));
            end
            cyc++;
        end
        chk("arvalid_seen", 64'(saw_ar), 64'(t.pc[1:0] == 2'b00));
    endtask

    // Monitor: checks the presented instruction on every HOLD cycle and
    // pc_update_o on every cycle, popping the scoreboard on acceptance
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (inst_valid_o) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'(inst_valid_o), 64'd0);
                end else begin
                    chk("inst",  inst_o,       sb_q[0].inst);
                    chk("pc",    inst_pc_o,    sb_q[0].pc);
                    chk("fault", inst_fault_o, sb_q[0].fault);
                    if (inst_ready_i) begin
                        chk("pc_update_accept", 64'(pc_update_o), 64'd1);
                        void'(sb_q.pop_front());
                    end else begin
                        chk("pc_update_stall", 64'(pc_update_o), 64'd0);
                    end
                end
            end else begin
                chk("pc_update_idle", 64'(pc_update_o), 64'd0);
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_arvalid",    64'(arvalid_o),    64'd0);
        chk("rst_rready",     64'(rready_o),     64'd0);
        chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
        chk("rst_pc_update",  64'(pc_update_o),  64'd0);
        chk("rst_inst",       inst_o,            NOP);
        chk("rst_inst_pc",    inst_pc_o,         32'd0);
        chk("rst_fault",      inst_fault_o,      2'd0);
    endtask

    txn_t dir[$];

    initial begin
        txn_t t;
        rst = 1'b0; pc_i = 32'h8000_0000;
        arready_i = 0; rvalid_i = 0; rresp_i = 0; rdata_i = 0; inst_ready_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b1;

        dir.push_back('{32'h8000_0000, 0, 0,    2'd0, 32'h0010_0093, 0}); // best case
        dir.push_back('{32'h8000_0004, 3, 1,    2'd0, 32'h0020_0113, 4}); // backpressure
        dir.push_back('{32'h8000_0002, 0, 0,    2'd0, 32'hDEAD_BEEF, 1}); // misaligned
        dir.push_back('{32'h8000_0008, 0, 0,    2'd2, 32'h1234_5678, 0}); // bus error
        dir.push_back('{32'h8000_000C, 0, 1000, 2'd0, 32'h0BAD_0BAD, 0}); // timeout
        dir.push_back('{32'h8000_0010, 1, TMO,  2'd0, 32'h00A0_0513, 2}); // data on last count
        dir.push_back('{32'h8000_0014, 0, TMO-1,2'd0, 32'h00B0_0593, 0});
        foreach (dir[i]) run_txn(dir[i]);

        for (int i = 0; i < 60; i++) begin
            t.pc = $urandom;
            if ($urandom_range(0, 4) != 0) t.pc[1:0] = 2'b00;
            else                           t.pc[1:0] = 2'($urandom_range(1, 3));
            t.ar_dly   = $urandom_range(0, 3);
            t.r_dly    = $urandom_range(0, TMO + 2);
            t.resp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            t.data     = $urandom;
            t.hold_dly = $urandom_range(0, 3);
            run_txn(t);
        end

        // Reset while waiting for read data; the late response must be dropped
        pc_i = 32'h8000_0100;
        @(negedge clk);                       // AR
        chk("mid_ar_arvalid", 64'(arvalid_o), 64'd1);
        arready_i = 1'b1; rvalid_i = 1'b0; inst_ready_i = 1'b0;
        @(negedge clk);                       // R
        chk("mid_r_rready", 64'(rready_o), 64'd1);
        rst = 1'b0; arready_i = 1'b0;
        @(negedge clk);                       // IDLE after reset
        check_reset_values();
        rst = 1'b1; rvalid_i = 1'b1; rresp_i = 2'd0; rdata_i = 32'hFFFF_FFFF;
        run_txn('{32'h8000_0100, 1, 2, 2'd0, 32'h0030_0193, 1});

        @(negedge clk);
        #3;
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
